// File: rtl/modinv_ctrl_pkg.sv
// Shared types and constants for the modular-inverse controller.
// Holds the default width, the FSM state encoding and the signed-width helper.
package modinv_ctrl_pkg;

  localparam int W_DEF    = 8;
  localparam int SW_EXTRA = 2;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_e;

  // The Bezout coefficients stay within +/- phi_n, so two extra bits cover sign and headroom.
  function automatic int signed_w(input int w);
    return w + SW_EXTRA;
  endfunction

endpackage

// File: rtl/modinv_ctrl_if.sv
// Request/response bundle between the key-setup sequencer and the modular-inverse controller.
interface modinv_ctrl_if
  import modinv_ctrl_pkg::*;
#(
  parameter int W = W_DEF
);

  logic         start;
  logic [W-1:0] e;
  logic [W-1:0] phi_n;
  logic         busy;
  logic         done;
  logic         err;
  logic [W-1:0] d;
  logic [W-1:0] iter_cnt;

  modport master (
    output start, e, phi_n,
    input  busy, done, err, d, iter_cnt
  );

  modport slave (
    input  start, e, phi_n,
    output busy, done, err, d, iter_cnt
  );

endinterface

// File: rtl/modinv_step.sv
// One extended-Euclid iteration: divides the remainders and updates both coefficients.
module modinv_step
  import modinv_ctrl_pkg::*;
#(
  parameter int W  = W_DEF,
  parameter int SW = signed_w(W)
) (
  input  logic        [W-1:0]  r1_i,
  input  logic        [W-1:0]  r2_i,
  input  logic signed [SW-1:0] t1_i,
  input  logic signed [SW-1:0] t2_i,
  output logic        [W-1:0]  r1n_o,
  output logic        [W-1:0]  r2n_o,
  output logic signed [SW-1:0] t1n_o,
  output logic signed [SW-1:0] t2n_o
);

  logic        [W-1:0]  q;
  logic        [W-1:0]  qr;
  logic signed [SW-1:0] q_ext;
  logic signed [SW-1:0] qt;

  // The divider is guarded so a zero divisor never produces X; the FSM never uses that result.
  assign q     = (r2_i == '0) ? '0 : r1_i / r2_i;
  assign qr    = q * r2_i;
  assign q_ext = $signed({{(SW-W){1'b0}}, q});
  assign qt    = q_ext * t2_i;

  assign r1n_o = r2_i;
  assign r2n_o = r1_i - qr;
  assign t1n_o = t2_i;
  assign t2n_o = t1_i - qt;

endmodule

// File: rtl/modinv_ctrl.sv
// Computes d = e^-1 mod phi_n by extended Euclid, one iteration per clock,
// with a start/busy/done handshake and an error flag for non-invertible inputs.
module modinv_ctrl
  import modinv_ctrl_pkg::*;
#(
  parameter int W = W_DEF
) (
  input logic         clk,
  input logic         rst_n,
  modinv_ctrl_if.slave bus
);

  localparam int SW = signed_w(W);

  state_e               state_q, state_d;
  logic        [W-1:0]  r1_q, r1_d, r2_q, r2_d;
  logic        [W-1:0]  phi_q, phi_d, d_q, d_d, iter_q, iter_d;
  logic signed [SW-1:0] t1_q, t1_d, t2_q, t2_d;
  logic                 ferr_q, ferr_d, busy_q, busy_d;
  logic                 done_q, done_d, err_q, err_d;

  logic        [W-1:0]  r1n, r2n;
  logic signed [SW-1:0] t1n, t2n;
  logic signed [SW-1:0] t1_mod;

  modinv_step #(.W(W), .SW(SW)) u_step (
    .r1_i  (r1_q),
    .r2_i  (r2_q),
    .t1_i  (t1_q),
    .t2_i  (t2_q),
    .r1n_o (r1n),
    .r2n_o (r2n),
    .t1n_o (t1n),
    .t2n_o (t2n)
  );

  assign t1_mod = t1_q + $signed({{(SW-W){1'b0}}, phi_q});

  always_comb begin
    // NOTE: every next-state value defaults to its current value first, so no path infers a latch.
    state_d = state_q;
    r1_d    = r1_q;
    r2_d    = r2_q;
    t1_d    = t1_q;
    t2_d    = t2_q;
    phi_d   = phi_q;
    ferr_d  = ferr_q;
    iter_d  = iter_q;
    busy_d  = busy_q;
    err_d   = err_q;
    d_d     = d_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          r1_d    = bus.phi_n;
          r2_d    = bus.e;
          t1_d    = '0;
          t2_d    = {{(SW-1){1'b0}}, 1'b1};
          phi_d   = bus.phi_n;
          iter_d  = '0;
          busy_d  = 1'b1;
          ferr_d  = (bus.e == '0) || (bus.phi_n < W'(2));
          state_d = ((bus.e == '0) || (bus.phi_n < W'(2))) ? FIN : RUN;
        end
      end
      RUN: begin
        if (r2_q != '0) begin
          r1_d   = r1n;
          r2_d   = r2n;
          t1_d   = t1n;
          t2_d   = t2n;
          iter_d = iter_q + W'(1);
        end else begin
          state_d = FIN;
        end
      end
      FIN: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
        if (ferr_q || (r1_q != W'(1))) begin
          err_d = 1'b1;
          d_d   = '0;
        end else begin
          err_d = 1'b0;
          // A negative coefficient is brought into [1, phi_n-1] before truncation.
          d_d   = t1_q[SW-1] ? t1_mod[W-1:0] : t1_q[W-1:0];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      r1_q    <= '0;
      r2_q    <= '0;
      t1_q    <= '0;
      t2_q    <= '0;
      phi_q   <= '0;
      ferr_q  <= 1'b0;
      iter_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      d_q     <= '0;
    end else begin
      state_q <= state_d;
      r1_q    <= r1_d;
      r2_q    <= r2_d;
      t1_q    <= t1_d;
      t2_q    <= t2_d;
      phi_q   <= phi_d;
      ferr_q  <= ferr_d;
      iter_q  <= iter_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      d_q     <= d_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.d        = d_q;
  assign bus.iter_cnt = iter_q;

endmodule

// File: tb/tb_modinv_ctrl.sv
// Directed bench for modinv_ctrl: 8-bit and 12-bit instances, hand-computed inverses,
// error shortcuts, held start, mid-job input changes and reset during a job.
module tb_modinv_ctrl;
  import modinv_ctrl_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  modinv_ctrl_if #(.W(8))  b8 ();
  modinv_ctrl_if #(.W(12)) b12 ();

  modinv_ctrl #(.W(8))  u8  (.clk(clk), .rst_n(rst_n), .bus(b8));
  modinv_ctrl #(.W(12)) u12 (.clk(clk), .rst_n(rst_n), .bus(b12));

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts edges after the acceptance edge until done is seen; -1 on timeout.
  task automatic wait_done8(output int lat);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!b8.done && lat < 200);
    if (!b8.done) lat = -1;
  endtask

  task automatic wait_done12(output int lat);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!b12.done && lat < 200);
    if (!b12.done) lat = -1;
  endtask

  task automatic start8(input logic [7:0] e, input logic [7:0] phi);
    b8.e     = e;
    b8.phi_n = phi;
    b8.start = 1'b1;
    tick();
    b8.start = 1'b0;
  endtask

  initial begin
    int lat;
    int pulses;

    b8.start  = 1'b0;
    b8.e      = '0;
    b8.phi_n  = '0;
    b12.start = 1'b0;
    b12.e     = '0;
    b12.phi_n = '0;

    tick();
    tick();
    check("rst_busy", b8.busy, 0);
    check("rst_done", b8.done, 0);
    check("rst_err",  b8.err, 0);
    check("rst_d",    b8.d, 0);
    check("rst_iter", b8.iter_cnt, 0);
    rst_n = 1'b1;
    tick();

    // e=7, phi_n=40: four iterations, negative t1 normalised to 23
    start8(8'd7, 8'd40);
    check("7_40_busy_run", b8.busy, 1);
    wait_done8(lat);
    check("7_40_lat",  lat, 6);
    check("7_40_d",    b8.d, 23);
    check("7_40_err",  b8.err, 0);
    check("7_40_iter", b8.iter_cnt, 4);
    check("7_40_busy_done", b8.busy, 0);
    tick();
    check("7_40_done_pulse", b8.done, 0);
    check("7_40_d_hold", b8.d, 23);

    start8(8'd3, 8'd20);
    wait_done8(lat);
    check("3_20_lat", lat, 5);
    check("3_20_d",   b8.d, 7);
    check("3_20_err", b8.err, 0);

    // gcd(6,20)=2
    start8(8'd6, 8'd20);
    wait_done8(lat);
    check("6_20_lat",  lat, 4);
    check("6_20_err",  b8.err, 1);
    check("6_20_d",    b8.d, 0);
    check("6_20_iter", b8.iter_cnt, 2);

    // e >= phi_n: first quotient is 0, result still 47 mod 40 = 7 -> 23
    start8(8'd47, 8'd40);
    wait_done8(lat);
    check("47_40_lat",  lat, 8);
    check("47_40_d",    b8.d, 23);
    check("47_40_iter", b8.iter_cnt, 6);

    // Forced-error shortcuts
    start8(8'd0, 8'd40);
    wait_done8(lat);
    check("e0_lat",  lat, 1);
    check("e0_err",  b8.err, 1);
    check("e0_d",    b8.d, 0);
    check("e0_iter", b8.iter_cnt, 0);
    start8(8'd5, 8'd1);
    wait_done8(lat);
    check("phi1_lat",  lat, 1);
    check("phi1_err",  b8.err, 1);
    check("phi1_d",    b8.d, 0);
    check("phi1_iter", b8.iter_cnt, 0);

    // 12-bit textbook RSA: e=17, phi=3120 -> d=2753
    b12.e     = 12'd17;
    b12.phi_n = 12'd3120;
    b12.start = 1'b1;
    tick();
    b12.start = 1'b0;
    wait_done12(lat);
    check("w12_lat",  lat, 6);
    check("w12_d",    b12.d, 2753);
    check("w12_err",  b12.err, 0);
    check("w12_iter", b12.iter_cnt, 4);

    // start held across two jobs, inputs changed mid-job
    b8.e     = 8'd3;
    b8.phi_n = 8'd20;
    b8.start = 1'b1;
    tick();
    b8.e     = 8'd7;
    b8.phi_n = 8'd40;
    wait_done8(lat);
    check("held1_lat",  lat, 5);
    check("held1_d",    b8.d, 7);
    check("held1_busy", b8.busy, 0);
    tick();
    check("held2_accept_busy", b8.busy, 1);
    check("held2_done_low",    b8.done, 0);
    b8.start = 1'b0;
    wait_done8(lat);
    check("held2_lat", lat, 6);
    check("held2_d",   b8.d, 23);

    // Reset in the middle of a job
    start8(8'd7, 8'd40);
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("rstrun_busy", b8.busy, 0);
    check("rstrun_d",    b8.d, 0);
    check("rstrun_done", b8.done, 0);
    check("rstrun_iter", b8.iter_cnt, 0);
    tick();
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (b8.done) pulses++;
    end
    check("rstrun_no_done", pulses, 0);
    start8(8'd7, 8'd40);
    wait_done8(lat);
    check("after_rst_lat", lat, 6);
    check("after_rst_d",   b8.d, 23);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
